// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_CAP_EN to force release after MAX_BURST beats.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16,
  parameter int GID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      stream_mode,
  input  logic [NUM_REQ-1:0]        s_req,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  output logic [NUM_REQ-1:0]        s_ack,
  output logic [NUM_REQ-1:0]        s_ack_pulse,
  output logic [NUM_REQ-1:0]        s_fifo_full,
  output logic                      m_req,
  output logic [DATA_W-1:0]         m_data,
  input  logic                      m_ack,
  input  logic                      m_fifo_full,
  output logic                      busy,
  output logic [GID_W-1:0]          grant_id
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t             r_state;
  logic [GID_W-1:0]   r_grant_id;
  logic [GID_W-1:0]   r_last_grant;
  logic [NUM_REQ-1:0] r_ack_pulse;

  logic               w_busy;
  logic               w_req_g;
  logic               w_accept;
  logic               w_release;
  logic               w_cap_hit;
  logic [GID_W-1:0]   w_pick;
  logic [NUM_REQ-1:0] w_ack;
  logic [NUM_REQ-1:0] w_pulse_nxt;
  logic [DATA_W-1:0]  w_data;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_req_g  = s_req[r_grant_id];
  assign w_accept = w_busy & w_req_g & m_ack;
  assign w_release = w_busy & (~w_req_g | w_cap_hit);

  // Descending offsets so the nearest requester after last_grant wins.
  always_comb begin
    int               v_idx;
    logic [GID_W-1:0] v_sel;
    v_idx  = 0;
    v_sel  = '0;
    w_pick = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      v_idx = int'(r_last_grant) + off;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      v_sel = GID_W'(v_idx);
      if (s_req[v_sel]) w_pick = v_sel;
    end
  end

  always_comb begin
    w_data = '0;
    if (w_busy)
      w_data = s_data[int'(r_grant_id)*DATA_W +: DATA_W];
  end

  always_comb begin
    w_ack = '0;
    if (w_busy) w_ack[r_grant_id] = m_ack;
  end

  always_comb begin
    w_pulse_nxt = '0;
    if (w_accept) w_pulse_nxt[r_grant_id] = 1'b1;
  end

`ifdef FIFO_ARB_BURST_CAP_EN
  logic [7:0] r_beat_cnt;
  wire        w_unused_mode = stream_mode;

  assign w_cap_hit = w_accept &
    (r_beat_cnt == 8'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_beat_cnt <= '0;
    end else if (!w_busy) begin
      r_beat_cnt <= '0;
    end else if (w_accept && r_beat_cnt != 8'hFF) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end
`else
  wire        w_unused_mode = stream_mode;
  wire  [7:0] w_unused_cap  = 8'(MAX_BURST - 1);

  assign w_cap_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_ack_pulse  <= '0;
    end else begin
      r_ack_pulse <= w_pulse_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (|s_req) begin
            r_grant_id <= w_pick;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_last_grant <= r_grant_id;
            r_state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign m_req       = w_busy & w_req_g;
  assign m_data      = w_data;
  assign s_ack       = w_ack;
  assign s_ack_pulse = r_ack_pulse;
  assign s_fifo_full = {NUM_REQ{m_fifo_full}};
  assign busy        = w_busy;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: requester models,
// expected-beat scoreboard and an arbitration vector table.
module tb_fifo_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  logic           clk;
  logic           rstn;
  logic           stream_mode;
  logic [NR-1:0]  s_req;
  logic [NR*DW-1:0] s_data;
  logic [NR-1:0]  s_ack;
  logic [NR-1:0]  s_ack_pulse;
  logic [NR-1:0]  s_fifo_full;
  logic           m_req;
  logic [DW-1:0]  m_data;
  logic           m_ack;
  logic           m_fifo_full;
  logic           busy;
  logic [1:0]     grant_id;

  fifo_push_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rstn(rstn), .stream_mode(stream_mode),
    .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
    .s_ack_pulse(s_ack_pulse), .s_fifo_full(s_fifo_full),
    .m_req(m_req), .m_data(m_data), .m_ack(m_ack),
    .m_fifo_full(m_fifo_full), .busy(busy),
    .grant_id(grant_id)
  );

  // FIFO model: acks whenever not full.
  assign m_ack = m_req & ~m_fifo_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          gid;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int         first;
    logic [3:0] pat;
    int         exp_gid;
  } arb_vec_t;

  exp_t      sbq[$];
  int        cnt[NR];
  int        idx[NR];
  bit        hold[NR];
  int        pulse_cnt[NR];
  logic [NR-1:0] acc;
  logic [NR-1:0] prev_acc;
  int        errors, checks, n_acc, idle_cnt, hold_gid;
  bit        sb_on;
  logic      smp_busy, smp_mreq;
  logic [1:0] smp_gid;

  function automatic logic [63:0] dval(int i, int k);
    return {32'hCAFE0000 + 32'(i), 32'h00000100 + 32'(k)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int g, input int k);
    exp_t e;
    e.gid  = g;
    e.data = dval(g, k);
    sbq.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      s_req[i] = (cnt[i] > 0) && !hold[i];
      s_data[i*DW +: DW] = dval(i, idx[i]);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    smp_busy = busy;
    smp_gid  = grant_id;
    smp_mreq = m_req;
    acc = s_ack & s_req;
    chk("ack_pulse", 64'(s_ack_pulse), 64'(prev_acc));
    chk("fifo_full_bc", 64'(s_fifo_full), {60'd0, {NR{m_fifo_full}}});
    if (m_req & m_ack) begin
      n_acc++;
      if (sb_on) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 64'(sbq.size()), 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("beat_gid", 64'(grant_id), 64'(e.gid));
          chk("beat_data", m_data, e.data);
          chk("beat_ack", 64'(s_ack), 64'(4'b0001 << e.gid));
        end
      end
    end
    if (!busy) begin
      chk("idle_ack_req", 64'({s_ack, m_req}), 64'd0);
      chk("idle_data", m_data, 64'd0);
    end
    if (hold_gid >= 0) begin
      chk("full_gid", 64'(grant_id), 64'(hold_gid));
      chk("full_busy", 64'(busy), 64'd1);
      chk("full_ack", 64'(s_ack), 64'd0);
    end
    if (rstn) begin
      if (!busy && s_req != '0) begin
        idle_cnt++;
      end else if (busy && idle_cnt > 0) begin
        chk("idle_gap", 64'(idle_cnt), 64'd1);
        idle_cnt = 0;
      end
    end
    for (int i = 0; i < NR; i++)
      if (s_ack_pulse[i]) pulse_cnt[i]++;
    prev_acc = rstn ? acc : '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        idx[i]++;
        cnt[i]--;
        hold[i] = !stream_mode;
      end else begin
        hold[i] = 1'b0;
      end
    end
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++)
      if (cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_done(input int budget);
    int c;
    c = 0;
    while ((pending() || smp_busy) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget)
      chk("timeout", 64'(c), 64'(budget - 1));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      idx[i] = 0;
      hold[i] = 1'b0;
      pulse_cnt[i] = 0;
    end
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    prev_acc = '0;
    idle_cnt = 0;
    n_acc = 0;
    smp_busy = 1'b0;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    arb_vec_t vt[7];
    int c;
    vt[0] = '{0, 4'b1111, 1};
    vt[1] = '{2, 4'b0011, 0};
    vt[2] = '{3, 4'b1000, 3};
    vt[3] = '{1, 4'b0110, 2};
    vt[4] = '{2, 4'b0100, 2};
    vt[5] = '{0, 4'b1001, 3};
    vt[6] = '{3, 4'b0111, 0};

    errors = 0;
    checks = 0;
    hold_gid = -1;
    sb_on = 1'b1;
    stream_mode = 1'b1;
    m_fifo_full = 1'b0;
    rstn = 1'b0;
    s_req = '0;
    s_data = '0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      idx[i] = 0;
      hold[i] = 1'b0;
      pulse_cnt[i] = 0;
    end
    drive();

    // Reset state, then a single streaming requester.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mreq", 64'(m_req), 64'd0);
    chk("rst_ack", 64'(s_ack), 64'd0);
    chk("rst_pulse", 64'(s_ack_pulse), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_data", m_data, 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    prev_acc = '0;
    idle_cnt = 0;
    n_acc = 0;
    smp_busy = 1'b0;
    cnt[2] = 5;
    for (int k = 0; k < 5; k++) push_exp(2, k);
    drive();
    step();
    chk("t1_wait_busy", 64'(smp_busy), 64'd0);
    step();
    chk("t1_busy", 64'(smp_busy), 64'd1);
    chk("t1_gid", 64'(smp_gid), 64'd2);
    run_until_done(50);
    chk("t1_pulses", 64'(pulse_cnt[2]), 64'd5);
    chk("t1_sb_left", 64'(sbq.size()), 64'd0);

    // Arbitration vector table: serve 'first', then raise 'pat'.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      sb_on = 1'b0;
      stream_mode = 1'b1;
      cnt[vt[r].first] = 1;
      drive();
      c = 0;
      while (!(n_acc >= 1 && !smp_busy) && c < 40) begin
        step();
        c++;
      end
      if (c >= 40) chk("vt_first_timeout", 64'(c), 64'd0);
      for (int i = 0; i < NR; i++) cnt[i] = vt[r].pat[i] ? 1 : 0;
      drive();
      step();
      step();
      chk("vt_busy", 64'(smp_busy), 64'd1);
      chk("vt_gid", 64'(smp_gid), 64'(vt[r].exp_gid));
      run_until_done(60);
      sb_on = 1'b1;
    end

    // Handshake-mode fairness.
    do_reset();
    stream_mode = 1'b0;
    for (int i = 0; i < NR; i++) cnt[i] = 3;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) push_exp(i, k);
    drive();
    run_until_done(200);
    chk("t2_sb_left", 64'(sbq.size()), 64'd0);
    chk("t2_beats", 64'(n_acc), 64'd12);

    // Burst cap with two streaming requesters.
    do_reset();
    stream_mode = 1'b1;
    cnt[0] = 10;
    cnt[1] = 10;
`ifdef FIFO_ARB_BURST_CAP_EN
    for (int b = 0; b < 3; b++) begin
      for (int g = 0; g < 2; g++) begin
        for (int k = b*4; k < b*4 + 4 && k < 10; k++)
          push_exp(g, k);
      end
    end
`else
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 10; k++) push_exp(g, k);
`endif
    drive();
    run_until_done(200);
    chk("t3_sb_left", 64'(sbq.size()), 64'd0);

    // FIFO full for six cycles mid-burst.
    do_reset();
    stream_mode = 1'b1;
    cnt[1] = 8;
    for (int k = 0; k < 8; k++) push_exp(1, k);
    drive();
    c = 0;
    while (n_acc < 3 && c < 50) begin
      step();
      c++;
    end
    if (c >= 50) chk("t4_pre_timeout", 64'(c), 64'd0);
    m_fifo_full = 1'b1;
    hold_gid = 1;
    repeat (6) step();
    chk("t4_no_beats", 64'(n_acc), 64'd3);
    chk("t4_pulses_full", 64'(pulse_cnt[1]), 64'd3);
    m_fifo_full = 1'b0;
    hold_gid = -1;
    run_until_done(60);
    chk("t4_sb_left", 64'(sbq.size()), 64'd0);
    chk("t4_pulses", 64'(pulse_cnt[1]), 64'd8);

    // Reset during requester 3's stream.
    do_reset();
    stream_mode = 1'b1;
    cnt[3] = 6;
    for (int k = 0; k < 3; k++) push_exp(3, k);
    drive();
    c = 0;
    while (n_acc < 2 && c < 50) begin
      step();
      c++;
    end
    if (c >= 50) chk("t5_pre_timeout", 64'(c), 64'd0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    cnt[0] = 2;
    push_exp(0, 0);
    push_exp(0, 1);
    for (int k = 3; k < 6; k++) push_exp(3, k);
    drive();
    step();
    chk("t5_rst_busy", 64'(smp_busy), 64'd0);
    chk("t5_rst_mreq", 64'(smp_mreq), 64'd0);
    chk("t5_rst_gid", 64'(smp_gid), 64'd0);
    step();
    chk("t5_first_busy", 64'(smp_busy), 64'd1);
    chk("t5_first_gid", 64'(smp_gid), 64'd0);
    run_until_done(80);
    chk("t5_sb_left", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
